serial_subtractor: RTL and testbench

//  Bit-serial N-bit subtractor; computes {bout,diff} = a - b - bin.

---
 rtl/serial_subtractor.sv | 136 +++++++++++++
 tb/tb_serial_subtractor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial N-bit subtractor computing {bout, diff} = a - b - bin.
//
// A three-state sequencer feeds a one-bit full-subtractor stage one operand bit per clock,
// LSB first. The borrow between bits lives in a flop, and difference bits collect in a
// right-shifting result register. When the last bit is done, the result is copied to the
// output registers and announced with a one-cycle done pulse.
//
// Ports
//   clk   in  1  single clock, rising edge
//   rst   in  1  synchronous active-high reset
//   start in  1  operation request, sampled only while idle
//   a     in  N  minuend, captured on an accepted start
//   b     in  N  subtrahend, captured on an accepted start
//   bin   in  1  borrow-in, captured on an accepted start
//   busy  out 1  high while bits are being processed
//   done  out 1  one-cycle pulse, diff/bout valid
//   diff  out N  (a - b - bin) mod 2^N, held until the next completion or reset
//   bout  out 1  final borrow-out, 1 when a < b + bin (unsigned)

module serial_subtractor #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
);

  // One extra counter bit so N = 1 and N = 2^k never wrap before the last bit.
  localparam int unsigned CntW = $clog2(N) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    a_sr_q, a_sr_d;
  logic [N-1:0]    b_sr_q, b_sr_d;
  logic [N-1:0]    res_sr_q, res_sr_d;
  logic            brw_q, brw_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    diff_q, diff_d;
  logic            bout_q, bout_d;

  // Full-subtractor stage on the current LSBs.
  logic         bit_d;
  logic         bit_nb;
  logic [N-1:0] msb_ins;
  logic [N-1:0] res_next;

  always_comb begin
    bit_d  = a_sr_q[0] ^ b_sr_q[0] ^ brw_q;
    bit_nb = (~a_sr_q[0] & b_sr_q[0]) | (brw_q & ~(a_sr_q[0] ^ b_sr_q[0]));
    // New bit enters at the MSB; built with a shift so N = 1 needs no special case.
    msb_ins        = '0;
    msb_ins[N-1]   = bit_d;
    res_next       = (res_sr_q >> 1) | msb_ins;
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = res_next;
        brw_d    = bit_nb;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          diff_d  = res_next;
          bout_d  = bit_nb;
          state_d = StDone;
        end
      end
      StDone: begin
        // start is deliberately ignored here; always return to idle.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      brw_q    <= brw_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: N = 8 directed cases plus exhaustive N = 4 and
// N = 1 sweeps. Expected {bout, diff} values are pushed to per-instance queues when an
// operation is driven and popped by monitors on each done pulse.

module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, bin8 = 1'b0, busy8, done8, bout8;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  logic       start4 = 1'b0, bin4 = 1'b0, busy4, done4, bout4;
  logic [3:0] a4 = '0, b4 = '0, diff4;
  logic       start1 = 1'b0, bin1 = 1'b0, busy1, done1, bout1;
  logic [0:0] a1 = '0, b1 = '0, diff1;

  serial_subtractor #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );
  serial_subtractor #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );
  serial_subtractor #(.N(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  int tests = 0;
  int fails = 0;

  // Scoreboards hold {bout, diff zero-extended to 8 bits}.
  logic [8:0] q8[$];
  logic [8:0] q4[$];
  logic [8:0] q1[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Independent reference: integer subtraction, sign gives the borrow.
  function automatic logic [8:0] ref_sub(input int w, input logic [7:0] av, input logic [7:0] bv,
                                         input logic bi);
    int mask;
    int r;
    mask = (1 << w) - 1;
    r = int'(av) & mask;
    r = r - (int'(bv) & mask) - int'(bi);
    return {(r < 0), 8'(r & mask)};
  endfunction

  // Monitors: pop on done, and check busy/done exclusivity every cycle.
  logic       armed = 1'b0;
  logic       rst_at_edge = 1'b1;
  logic [8:0] prev8 = '0;
  always @(posedge clk) rst_at_edge <= rst;

  always @(negedge clk) begin
    if (armed) begin
      check("excl8", {31'b0, busy8 & done8}, 32'd0);
      check("excl4", {31'b0, busy4 & done4}, 32'd0);
      check("excl1", {31'b0, busy1 & done1}, 32'd0);
      // diff/bout may only move on a completion or a reset.
      if (!done8 && !rst_at_edge) check("hold8", {23'b0, bout8, diff8}, {23'b0, prev8});
      if (done8) begin
        if (q8.size() == 0) check("spurious_done8", 32'd1, 32'd0);
        else check("result8", {23'b0, bout8, diff8}, {23'b0, q8.pop_front()});
      end
      if (done4) begin
        if (q4.size() == 0) check("spurious_done4", 32'd1, 32'd0);
        else check("result4", {23'b0, bout4, 4'b0, diff4}, {23'b0, q4.pop_front()});
      end
      if (done1) begin
        if (q1.size() == 0) check("spurious_done1", 32'd1, 32'd0);
        else check("result1", {23'b0, bout1, 7'b0, diff1}, {23'b0, q1.pop_front()});
      end
    end
    prev8 <= {bout8, diff8};
  end

  // Drive one operation into the selected instance and check latency and busy length.
  task automatic op(input int w, input logic [7:0] av, input logic [7:0] bv, input logic bi);
    int  busy_cnt;
    bit  seen;
    logic b_s, d_s;
    busy_cnt = 0;
    seen = 0;
    @(negedge clk);
    case (w)
      8: begin q8.push_back(ref_sub(8, av, bv, bi)); a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1; end
      4: begin q4.push_back(ref_sub(4, av, bv, bi)); a4 = av[3:0]; b4 = bv[3:0]; bin4 = bi;
               start4 = 1'b1; end
      default: begin q1.push_back(ref_sub(1, av, bv, bi)); a1 = av[0]; b1 = bv[0]; bin1 = bi;
                     start1 = 1'b1; end
    endcase
    @(negedge clk);
    start8 = 1'b0; start4 = 1'b0; start1 = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      case (w)
        8: begin b_s = busy8; d_s = done8; end
        4: begin b_s = busy4; d_s = done4; end
        default: begin b_s = busy1; d_s = done1; end
      endcase
      if (d_s) begin
        check("done_latency", k, w);
        seen = 1;
      end else begin
        if (b_s) busy_cnt++;
        @(negedge clk);
      end
    end
    if (!seen) check("done_timeout", 32'd1, 32'd0);
    else check("busy_cycles", busy_cnt, w);
  endtask

  task automatic wait_done8();
    bit seen;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done8) seen = 1;
    end
    if (!seen) check("done8_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int last;
    int ndone;
    int cyc;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy8", {31'b0, busy8}, 32'd0);
    check("rst_done8", {31'b0, done8}, 32'd0);
    check("rst_res8", {23'b0, bout8, diff8}, 32'd0);
    check("rst_res4", {27'b0, bout4, diff4}, 32'd0);
    check("rst_res1", {30'b0, bout1, diff1}, 32'd0);
    rst = 1'b0;
    armed = 1'b1;

    // Basic, negative results, borrow-in.
    op(8, 8'h5A, 8'h23, 1'b0);
    check("t1_diff", {24'b0, diff8}, 32'h37);
    op(8, 8'h00, 8'h01, 1'b0);
    op(8, 8'hFF, 8'hFF, 1'b1);
    check("t2_res", {23'b0, bout8, diff8}, 32'h1FF);

    // start held high: accepted only in idle, done every 10 cycles.
    repeat (3) q8.push_back(9'h07F);
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h00; bin8 = 1'b1; start8 = 1'b1;
    last = -1; ndone = 0; cyc = 0;
    while (ndone < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done8) begin
        if (last >= 0) check("t3_period", cyc - last, 32'd10);
        last = cyc;
        ndone++;
        if (ndone == 3) start8 = 1'b0;
      end
    end
    check("t3_count", ndone, 32'd3);

    // Inputs and a start pulse during RUN are ignored.
    @(negedge clk);
    q8.push_back(9'h00F);
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1;
    repeat (2) @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8();
    repeat (2) @(negedge clk);
    check("t4_no_restart", {31'b0, busy8}, 32'd0);

    // Reset sampled on the 4th RUN edge discards the partial result.
    a8 = 8'h5A; b8 = 8'h23; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", {31'b0, busy8}, 32'd0);
    check("t5_done", {31'b0, done8}, 32'd0);
    check("t5_res", {23'b0, bout8, diff8}, 32'd0);
    repeat (12) @(negedge clk);
    check("t5_idle", {30'b0, busy8, done8}, 32'd0);
    op(8, 8'h03, 8'h05, 1'b0);
    check("t5_new", {23'b0, bout8, diff8}, 32'h1FE);

    // Exhaustive narrow widths.
    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int bi = 0; bi < 2; bi++)
          op(4, 8'(av), 8'(bv), 1'(bi));
    for (int av = 0; av < 2; av++)
      for (int bv = 0; bv < 2; bv++)
        for (int bi = 0; bi < 2; bi++)
          op(1, 8'(av), 8'(bv), 1'(bi));

    repeat (3) @(negedge clk);
    check("q8_empty", q8.size(), 32'd0);
    check("q4_empty", q4.size(), 32'd0);
    check("q1_empty", q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
